redirect_ctrl: RTL and testbench

Sequences control-flow redirects resolved by the branch unit and trap logic into a pipeline flush followed by a fetch redirect. It sits between the execute-stage branch unit (`mispredict_o`, `instr_jump_o`, `jump_addr_o`) and the fetch stage. It owns the flush window length, arbitrates trap versus branch redirects, and holds the target address until fetch accepts it. It also counts taken redirects for performance monitoring.

---
 rtl/redirect_ctrl.sv | 94 +++++++++
 tb/tb_redirect_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/redirect_ctrl.sv
// rtl/redirect_ctrl.sv - sequences branch/trap redirects into a flush window and a fetch redirect
module redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 bu_valid_i,
    input  logic                 bu_mispredict_i,
    input  logic                 bu_instr_jump_i,
    input  logic [31:0]          bu_jump_addr_i,
    output logic                 bu_ready_o,
    input  logic                 trap_valid_i,
    input  logic [31:0]          trap_addr_i,
    output logic                 flush_o,
    output logic                 redirect_valid_o,
    output logic [31:0]          redirect_addr_o,
    input  logic                 fetch_ready_i,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] redirect_cnt_o
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic [31:0]          target_q, target_d;
    logic [CNT_WIDTH-1:0] rcnt_q, rcnt_d;

    logic branch_evt;
    logic accept;

    assign branch_evt = bu_valid_i & (state_q == IDLE) & (bu_mispredict_i | bu_instr_jump_i);
    assign accept     = trap_valid_i | branch_evt;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        target_d = target_q;
        rcnt_d   = rcnt_q;
        if (accept) begin
            // A trap preempts everything, including a same-cycle branch or fetch handshake.
            state_d  = FLUSH;
            fcnt_d   = FW'(FLUSH_CYCLES);
            target_d = trap_valid_i ? {trap_addr_i[31:1], 1'b0} : {bu_jump_addr_i[31:1], 1'b0};
            if (rcnt_q != {CNT_WIDTH{1'b1}}) begin
                rcnt_d = rcnt_q + 1'b1;
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    if (fcnt_q == FW'(1)) begin
                        state_d = REDIRECT;
                    end
                    fcnt_d = fcnt_q - 1'b1;
                end
                REDIRECT: begin
                    if (fetch_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            fcnt_q   <= '0;
            target_q <= '0;
            rcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            target_q <= target_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign bu_ready_o       = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign flush_o          = (state_q == FLUSH);
    assign redirect_valid_o = (state_q == REDIRECT);
    assign redirect_addr_o  = target_q;
    assign redirect_cnt_o   = rcnt_q;

endmodule

// File: tb/tb_redirect_ctrl.sv
// tb/tb_redirect_ctrl.sv - directed self-checking bench for redirect_ctrl
module tb_redirect_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        bu_valid_i, bu_mispredict_i, bu_instr_jump_i;
    logic [31:0] bu_jump_addr_i;
    logic        bu_ready_o;
    logic        trap_valid_i;
    logic [31:0] trap_addr_i;
    logic        flush_o, redirect_valid_o;
    logic [31:0] redirect_addr_o;
    logic        fetch_ready_i;
    logic        busy_o;
    logic [15:0] redirect_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bu_valid_i(bu_valid_i), .bu_mispredict_i(bu_mispredict_i),
        .bu_instr_jump_i(bu_instr_jump_i), .bu_jump_addr_i(bu_jump_addr_i),
        .bu_ready_o(bu_ready_o),
        .trap_valid_i(trap_valid_i), .trap_addr_i(trap_addr_i),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o),
        .redirect_addr_o(redirect_addr_o), .fetch_ready_i(fetch_ready_i),
        .busy_o(busy_o), .redirect_cnt_o(redirect_cnt_o)
    );

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        bu_valid_i = 0; bu_mispredict_i = 0; bu_instr_jump_i = 0; bu_jump_addr_i = 0;
        trap_valid_i = 0; trap_addr_i = 0;
    endtask

    task automatic test_reset();
        idle_inputs(); fetch_ready_i = 1; rst_i = 1;
        tick(); tick();
        rst_i = 0;
        n_checks++; if (flush_o !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", flush_o); end
        n_checks++; if (redirect_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rv got %b want 0", redirect_valid_o); end
        n_checks++; if (redirect_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", redirect_addr_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (redirect_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", redirect_cnt_o); end
        n_checks++; if (bu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bu_ready_o); end
    endtask

    task automatic test_taken_beq();
        bu_valid_i = 1; bu_mispredict_i = 1; bu_jump_addr_i = 32'h0000_1040; fetch_ready_i = 1;
        tick(); idle_inputs();
        n_checks++; if ({flush_o, redirect_valid_o, bu_ready_o, busy_o} !== 4'b1001) begin n_fail++; $display("FAIL beq_flush1 got %b want 1001", {flush_o, redirect_valid_o, bu_ready_o, busy_o}); end
        tick();
        n_checks++; if ({flush_o, redirect_valid_o} !== 2'b10) begin n_fail++; $display("FAIL beq_flush2 got %b want 10", {flush_o, redirect_valid_o}); end
        tick();
        n_checks++; if ({flush_o, redirect_valid_o} !== 2'b01) begin n_fail++; $display("FAIL beq_redir got %b want 01", {flush_o, redirect_valid_o}); end
        n_checks++; if (redirect_addr_o !== 32'h0000_1040) begin n_fail++; $display("FAIL beq_addr got %h want 00001040", redirect_addr_o); end
        n_checks++; if (redirect_cnt_o !== 16'd1) begin n_fail++; $display("FAIL beq_cnt got %0d want 1", redirect_cnt_o); end
        tick();
        n_checks++; if ({redirect_valid_o, busy_o, bu_ready_o} !== 3'b001) begin n_fail++; $display("FAIL beq_idle got %b want 001", {redirect_valid_o, busy_o, bu_ready_o}); end
    endtask

    task automatic test_jalr_odd();
        bu_valid_i = 1; bu_instr_jump_i = 1; bu_jump_addr_i = 32'h0000_2003; fetch_ready_i = 1;
        tick(); idle_inputs(); tick(); tick();
        n_checks++; if (redirect_valid_o !== 1'b1) begin n_fail++; $display("FAIL jalr_rv got %b want 1", redirect_valid_o); end
        n_checks++; if (redirect_addr_o !== 32'h0000_2002) begin n_fail++; $display("FAIL jalr_addr got %h want 00002002", redirect_addr_o); end
        n_checks++; if (redirect_cnt_o !== 16'd2) begin n_fail++; $display("FAIL jalr_cnt got %0d want 2", redirect_cnt_o); end
        tick();
    endtask

    task automatic test_not_taken();
        bu_valid_i = 1; bu_jump_addr_i = 32'h0000_5000;
        tick(); idle_inputs();
        n_checks++; if ({flush_o, busy_o, bu_ready_o} !== 3'b001) begin n_fail++; $display("FAIL nt_state got %b want 001", {flush_o, busy_o, bu_ready_o}); end
        n_checks++; if (redirect_cnt_o !== 16'd2) begin n_fail++; $display("FAIL nt_cnt got %0d want 2", redirect_cnt_o); end
    endtask

    task automatic test_simultaneous();
        bu_valid_i = 1; bu_mispredict_i = 1; bu_jump_addr_i = 32'h0000_0100;
        trap_valid_i = 1; trap_addr_i = 32'h8000_0000; fetch_ready_i = 1;
        tick(); idle_inputs();
        n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL sim_flush got %b want 1", flush_o); end
        tick(); tick();
        n_checks++; if (redirect_addr_o !== 32'h8000_0000) begin n_fail++; $display("FAIL sim_addr got %h want 80000000", redirect_addr_o); end
        n_checks++; if (redirect_cnt_o !== 16'd3) begin n_fail++; $display("FAIL sim_cnt got %0d want 3", redirect_cnt_o); end
        tick();
    endtask

    task automatic test_trap_in_redirect();
        bu_valid_i = 1; bu_mispredict_i = 1; bu_jump_addr_i = 32'h0000_0200; fetch_ready_i = 0;
        tick();
        // keep offering a different branch while busy; it must not be taken
        bu_jump_addr_i = 32'h0000_0999;
        tick(); tick();
        n_checks++; if ({redirect_valid_o, redirect_addr_o} !== {1'b1, 32'h0000_0200}) begin n_fail++; $display("FAIL tr_redir got %b %h want 1 00000200", redirect_valid_o, redirect_addr_o); end
        tick(); tick();
        n_checks++; if ({redirect_valid_o, bu_ready_o, redirect_addr_o} !== {2'b10, 32'h0000_0200}) begin n_fail++; $display("FAIL tr_hold got %b %b %h want 1 0 00000200", redirect_valid_o, bu_ready_o, redirect_addr_o); end
        idle_inputs();
        trap_valid_i = 1; trap_addr_i = 32'h8000_0004; fetch_ready_i = 1;
        tick(); trap_valid_i = 0;
        n_checks++; if ({flush_o, redirect_valid_o, bu_ready_o} !== 3'b100) begin n_fail++; $display("FAIL tr_reflush got %b want 100", {flush_o, redirect_valid_o, bu_ready_o}); end
        tick();
        n_checks++; if ({flush_o, bu_ready_o} !== 2'b10) begin n_fail++; $display("FAIL tr_flush2 got %b want 10", {flush_o, bu_ready_o}); end
        tick();
        n_checks++; if ({redirect_valid_o, redirect_addr_o} !== {1'b1, 32'h8000_0004}) begin n_fail++; $display("FAIL tr_addr got %b %h want 1 80000004", redirect_valid_o, redirect_addr_o); end
        n_checks++; if (redirect_cnt_o !== 16'd5) begin n_fail++; $display("FAIL tr_cnt got %0d want 5", redirect_cnt_o); end
        tick();
        n_checks++; if (bu_ready_o !== 1'b1) begin n_fail++; $display("FAIL tr_idle got %b want 1", bu_ready_o); end
    endtask

    task automatic test_reset_mid_flush();
        bu_valid_i = 1; bu_instr_jump_i = 1; bu_jump_addr_i = 32'h0000_0400; fetch_ready_i = 1;
        tick(); idle_inputs();
        n_checks++; if (flush_o !== 1'b1) begin n_fail++; $display("FAIL rmf_pre got %b want 1", flush_o); end
        rst_i = 1;
        tick(); rst_i = 0;
        n_checks++; if ({flush_o, redirect_valid_o, busy_o, bu_ready_o} !== 4'b0001) begin n_fail++; $display("FAIL rmf_state got %b want 0001", {flush_o, redirect_valid_o, busy_o, bu_ready_o}); end
        n_checks++; if ({redirect_addr_o, redirect_cnt_o} !== 48'h0) begin n_fail++; $display("FAIL rmf_regs got %h %0d want 0 0", redirect_addr_o, redirect_cnt_o); end
        bu_valid_i = 1; bu_mispredict_i = 1; bu_jump_addr_i = 32'h0000_0300;
        tick(); idle_inputs();
        n_checks++; if ({flush_o, redirect_cnt_o} !== {1'b1, 16'd1}) begin n_fail++; $display("FAIL rmf_accept got %b %0d want 1 1", flush_o, redirect_cnt_o); end
        tick(); tick();
        n_checks++; if (redirect_addr_o !== 32'h0000_0300) begin n_fail++; $display("FAIL rmf_addr got %h want 00000300", redirect_addr_o); end
        tick();
    endtask

    initial begin
        idle_inputs(); fetch_ready_i = 1; rst_i = 1;
        test_reset();
        test_taken_beq();
        test_jalr_odd();
        test_not_taken();
        test_simultaneous();
        test_trap_in_redirect();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
